// File: rtl/bus_pkg.sv
// Shared bus definitions: line geometry, bridge state encoding, error word.
package bus_pkg;

    localparam int          LINE_W   = 512;
    localparam int          IDX_W    = 4;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } bus_state_e;

endpackage

// File: rtl/line_lane_mux.sv
// Word/line lane steering: selects one 32-bit word out of a line and places a
// 4-bit byte mask into the matching lane of a line-wide byte mask.
module line_lane_mux #(
    parameter int LINE_W = 512
) (
    input  logic [LINE_W-1:0]   line,
    input  logic [3:0]          idx,
    input  logic [3:0]          dm,
    output logic [31:0]         word,
    output logic [LINE_W/8-1:0] line_dm
);

    localparam int DM_W = LINE_W / 8;

    // Lane select and mask placement, both indexed by the word index.
    always_comb begin
        word    = line[{idx, 5'b00000} +: 32];
        line_dm = {{(DM_W-4){1'b0}}, dm} << {idx, 2'b00};
    end

endmodule

// File: rtl/dbus_line_bridge.sv
// DBus word access to Wishbone line-cycle bridge with bounded-wait timeout.
// A word access stalls the CPU (nak) until the line cycle is acknowledged or
// times out; the response is presented for one DONE cycle.
module dbus_line_bridge
    import bus_pkg::*;
#(
    parameter int          LINE_W   = bus_pkg::LINE_W,
    parameter int          TIMEOUT  = 1024,
    parameter logic [31:0] ERR_DATA = bus_pkg::ERR_DATA
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [31:0]         addr,
    input  logic [31:0]         din,
    input  logic [3:0]          dm,
    output logic [31:0]         dout,
    output logic                nak,
    output logic [31:0]         ws_addr,
    output logic [LINE_W-1:0]   ws_din,
    output logic [LINE_W/8-1:0] ws_dm,
    output logic                ws_cyc,
    output logic                ws_stb,
    output logic                ws_we,
    input  logic                ws_ack,
    input  logic [LINE_W-1:0]   ws_dout,
    output logic                err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    bus_state_e           state_r;
    bus_state_e           next_state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [3:0]           idx_r;
    logic [3:0]           idx_sel_s;
    logic                 timeout_s;
    logic                 nak_s;
    logic [31:0]          rd_word_s;
    logic [LINE_W/8-1:0]  place_dm_s;
    logic [31:0]          dout_r;
    logic [31:0]          ws_addr_r;
    logic [LINE_W-1:0]    ws_din_r;
    logic [LINE_W/8-1:0]  ws_dm_r;
    logic                 ws_cyc_r;
    logic                 ws_stb_r;
    logic                 ws_we_r;
    logic                 err_r;

    // The mask is placed from the live address while idle; the read word is
    // selected with the latched index while the cycle is outstanding.
    assign idx_sel_s = (state_r == IDLE) ? addr[5:2] : idx_r;
    assign timeout_s = (state_r == REQ) && (cnt_r == CNT_W'(TIMEOUT - 1));

    line_lane_mux #(
        .LINE_W (LINE_W)
    ) u_lane_mux (
        .line    (ws_dout),
        .idx     (idx_sel_s),
        .dm      (dm),
        .word    (rd_word_s),
        .line_dm (place_dm_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and the combinational stall request.
    always_comb begin
        next_state_s = state_r;
        nak_s        = 1'b0;
        case (state_r)
            IDLE: begin
                nak_s = en;
                if (en) begin
                    next_state_s = REQ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            REQ: begin
                nak_s = 1'b1;
                if (ws_ack || timeout_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = REQ;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Request latching, Wishbone strobes, timeout counter and response data.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= '0;
            idx_r     <= 4'd0;
            dout_r    <= 32'd0;
            ws_addr_r <= 32'd0;
            ws_din_r  <= '0;
            ws_dm_r   <= '0;
            ws_cyc_r  <= 1'b0;
            ws_stb_r  <= 1'b0;
            ws_we_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (en) begin
                        idx_r     <= addr[5:2];
                        ws_addr_r <= {addr[31:6], 6'b000000};
                        ws_din_r  <= {(LINE_W/32){din}};
                        ws_dm_r   <= place_dm_s;
                        ws_we_r   <= (dm != 4'b0000);
                        ws_cyc_r  <= 1'b1;
                        ws_stb_r  <= 1'b1;
                    end
                end
                REQ: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (ws_ack) begin
                        ws_cyc_r <= 1'b0;
                        ws_stb_r <= 1'b0;
                        if (!ws_we_r) begin
                            dout_r <= rd_word_s;
                        end
                    end else if (timeout_s) begin
                        ws_cyc_r <= 1'b0;
                        ws_stb_r <= 1'b0;
                        err_r    <= 1'b1;
                        if (!ws_we_r) begin
                            dout_r <= ERR_DATA;
                        end
                    end
                end
                DONE: begin
                    cnt_r <= '0;
                end
                default: begin
                    cnt_r    <= '0;
                    ws_cyc_r <= 1'b0;
                    ws_stb_r <= 1'b0;
                end
            endcase
        end
    end

    assign nak     = nak_s;
    assign dout    = dout_r;
    assign ws_addr = ws_addr_r;
    assign ws_din  = ws_din_r;
    assign ws_dm   = ws_dm_r;
    assign ws_cyc  = ws_cyc_r;
    assign ws_stb  = ws_stb_r;
    assign ws_we   = ws_we_r;
    assign err     = err_r;

endmodule

// File: tb/tb_dbus_line_bridge.sv
// Self-checking bench for dbus_line_bridge against a transaction-level model.
module tb_dbus_line_bridge;

    localparam int LW = 512;
    localparam int TO = 8;

    logic            clk;
    logic            rst;
    logic            en;
    logic [31:0]     addr;
    logic [31:0]     din;
    logic [3:0]      dm;
    logic [31:0]     dout;
    logic            nak;
    logic [31:0]     ws_addr;
    logic [LW-1:0]   ws_din;
    logic [LW/8-1:0] ws_dm;
    logic            ws_cyc;
    logic            ws_stb;
    logic            ws_we;
    logic            ws_ack;
    logic [LW-1:0]   ws_dout;
    logic            err;

    int err_cnt;
    int chk_cnt;

    // Model state visible to the CPU.
    logic [31:0] dout_m;
    logic        err_m;

    dbus_line_bridge #(
        .LINE_W  (LW),
        .TIMEOUT (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .addr    (addr),
        .din     (din),
        .dm      (dm),
        .dout    (dout),
        .nak     (nak),
        .ws_addr (ws_addr),
        .ws_din  (ws_din),
        .ws_dm   (ws_dm),
        .ws_cyc  (ws_cyc),
        .ws_stb  (ws_stb),
        .ws_we   (ws_we),
        .ws_ack  (ws_ack),
        .ws_dout (ws_dout),
        .err     (err)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW/8-1:0] model_dm(input logic [31:0] a, input logic [3:0] m);
        logic [LW/8-1:0] r;
        int lane;
        lane = int'(a[5:2]);
        r = '0;
        for (int b = 0; b < LW/8; b++) begin
            if (b / 4 == lane) r[b] = m[b % 4];
        end
        return r;
    endfunction

    function automatic logic [LW-1:0] model_din(input logic [31:0] d);
        logic [LW-1:0] r;
        for (int j = 0; j < LW/32; j++) r[j*32 +: 32] = d;
        return r;
    endfunction

    function automatic logic [31:0] model_word(input logic [LW-1:0] l, input logic [31:0] a);
        logic [LW-1:0] s;
        s = l >> (32 * int'(a[5:2]));
        return s[31:0];
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int j = 0; j < LW/32; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    // One CPU access, starting and ending at a falling edge with the bridge idle.
    // ack_at: REQ cycle number (1-based) that sees ack; 0 means never.
    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          input logic [LW-1:0] line, input int ack_at, input bit keep_en);
        int  cycles;
        int  nreq;
        bit  acked;
        bit  rd;
        acked = (ack_at >= 1) && (ack_at <= TO);
        nreq  = acked ? ack_at : TO;
        rd    = (m == 4'b0000);
        en = 1'b1; addr = a; din = d; dm = m; ws_dout = line;
        #1;
        check_eq("idle_cyc_low", ws_cyc, 0);
        check_eq("nak_on_en", nak, 1);
        @(posedge clk); @(negedge clk);
        check_eq("cyc_rise", ws_cyc, 1);
        cycles = 0;
        while (ws_cyc && cycles < TO + 4) begin
            cycles++;
            check_eq("req_stb", ws_stb, 1);
            check_eq("req_nak", nak, 1);
            check_eq("req_addr", ws_addr, {a[31:6], 6'b000000});
            check_eq("req_we", ws_we, !rd);
            check_eq("req_dm", ws_dm, model_dm(a, m));
            check_eq("req_din", ws_din, model_din(d));
            ws_ack = (cycles == ack_at);
            @(posedge clk); @(negedge clk);
            ws_ack = 1'b0;
        end
        check_eq("cyc_len", cycles, nreq);
        if (rd) dout_m = acked ? model_word(line, a) : 32'hDEAD_BEEF;
        if (!acked) err_m = 1'b1;
        check_eq("done_nak", nak, 0);
        check_eq("done_cyc", ws_cyc, 0);
        check_eq("done_stb", ws_stb, 0);
        check_eq("done_dout", dout, dout_m);
        check_eq("done_err", err, err_m);
        if (!keep_en) en = 1'b0;
        @(posedge clk); @(negedge clk);
        if (!keep_en) begin
            #1;
            check_eq("post_cyc", ws_cyc, 0);
            check_eq("post_nak", nak, 0);
        end
    endtask

    // Stimulus sequence.
    initial begin
        logic [LW-1:0] line;
        logic [31:0]   ra;
        logic [3:0]    rm;
        err_cnt = 0; chk_cnt = 0;
        rst = 1'b1; en = 1'b0; addr = 32'd0; din = 32'd0; dm = 4'd0;
        ws_ack = 1'b0; ws_dout = '0;
        dout_m = 32'd0; err_m = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_cyc", ws_cyc, 0);
        check_eq("rst_stb", ws_stb, 0);
        check_eq("rst_we", ws_we, 0);
        check_eq("rst_addr", ws_addr, 0);
        check_eq("rst_dm", ws_dm, 0);
        check_eq("rst_din", ws_din, 0);
        check_eq("rst_dout", dout, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_nak", nak, 0);

        // Read with immediate ack, lane 2.
        line = rand_line();
        line[95:64] = 32'h1234_5678;
        access(32'h0000_1048, $urandom, 4'b0000, line, 1, 1'b0);
        check_eq("t1_dout", dout, 32'h1234_5678);

        // Write acked in the fifth REQ cycle, top lane.
        access(32'h0000_207C, 32'hCAFE_F00D, 4'b0011, rand_line(), 5, 1'b0);

        // Ack coincides with the last allowed cycle: no error.
        access($urandom, $urandom, 4'b0000, rand_line(), TO, 1'b0);

        // Ack while idle is ignored.
        ws_ack = 1'b1;
        @(posedge clk); @(negedge clk);
        ws_ack = 1'b0;
        check_eq("idle_ack_cyc", ws_cyc, 0);
        check_eq("idle_ack_nak", nak, 0);

        // Randomized good accesses.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rm = ($urandom_range(1) == 1) ? 4'($urandom_range(15)) : 4'b0000;
            access(ra, $urandom, rm, rand_line(), $urandom_range(6, 1), 1'b0);
        end

        // Read timeout, then a write timeout, then good accesses keep err set.
        access(32'h0000_3000, $urandom, 4'b0000, rand_line(), 0, 1'b0);
        check_eq("t3_dout", dout, 32'hDEAD_BEEF);
        access($urandom, $urandom, 4'b1111, rand_line(), 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            access($urandom, $urandom, 4'($urandom_range(15)), rand_line(), $urandom_range(3, 1), 1'b0);
        end
        check_eq("t3_err_sticky", err, 1);

        // en held across two back-to-back accesses.
        access(32'h0000_0000, $urandom, 4'b0000, rand_line(), 2, 1'b1);
        access(32'h0000_0040, $urandom, 4'b0000, rand_line(), 1, 1'b0);

        // Reset during the third REQ cycle, then a late ack.
        en = 1'b1; addr = 32'h0000_5004; din = $urandom; dm = 4'b0000;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check_eq("t5_cyc_req3", ws_cyc, 1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; en = 1'b0; ws_ack = 1'b1;
        dout_m = 32'd0; err_m = 1'b0;
        #1;
        check_eq("t5_cyc", ws_cyc, 0);
        check_eq("t5_nak", nak, 0);
        check_eq("t5_err", err, 0);
        @(posedge clk); @(negedge clk);
        ws_ack = 1'b0;
        check_eq("t5_late_ack_cyc", ws_cyc, 0);
        check_eq("t5_late_ack_nak", nak, 0);
        check_eq("t5_dout", dout, 0);
        access($urandom, $urandom, 4'b0000, rand_line(), 3, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/dbus_line_bridge.md
Name: dbus_line_bridge

Overview:
- CPU-bus peripheral responder that turns single-word DBus accesses into 512-bit line cycles as a Wishbone master toward the L2 cache slave port.
- Sits beside the other CPUBus peripherals and uses the nak stall signal, which the existing peripherals tie low.
- Gives uncached, device-ordered word access to DDR/SRAM-backed memory without going through the L1 caches.
- Includes a bounded-wait timeout so a missing ack cannot hang the CPU.

Parameters:
- LINE_W, 512, Wishbone data width in bits; DM width is LINE_W/8.
- TIMEOUT, 1024, maximum REQ cycles without ack before the cycle is aborted; must be ≥2.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clk  in  1  bus clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  select from CPUBus decode, already qualified by stbDBus.
- addr  in  32  byte address; bits [1:0] ignored.
- din  in  32  write data from CPU.
- dm  in  4  byte write mask; dm != 0 means write, dm == 0 means read.
- dout  out  32  read data to CPUBus.
- nak  out  1  stall request to CPUBus.
- ws_addr  out  32  line address = {addr[31:6],6'b0}.
- ws_din  out  LINE_W  write line, with din replicated into every 32-bit lane.
- ws_dm  out  LINE_W/8  byte mask; dm placed at bits [4*idx+3:4*idx], idx = addr[5:2], zero elsewhere.
- ws_cyc  out  1  Wishbone cycle.
- ws_stb  out  1  Wishbone strobe.
- ws_we  out  1  Wishbone write enable.
- ws_ack  in  1  Wishbone acknowledge.
- ws_dout  in  LINE_W  read line.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset values: state=IDLE; ws_cyc=ws_stb=ws_we=0; ws_addr=0; ws_dm=0; ws_din=0; dout=0; err=0; timeout counter=0.
- States:
  - IDLE: waits for en; counter held at 0.
  - REQ: Wishbone cycle outstanding.
  - DONE: response cycle.
- IDLE + en at edge T0:
  - latch addr, din, dm, idx;
  - ws_we = (dm != 0);
  - next state REQ at T1.
- nak is combinational:
  - nak = (state==IDLE & en) | (state==REQ).
  - nak = 0 in DONE.
  - The CPU holds addr/din/dm stable while nak=1.
- REQ:
  - ws_cyc = ws_stb = 1, driven from registers.
  - ws_addr/ws_din/ws_dm stay constant for the whole REQ state.
  - Counter increments each REQ cycle.
- ack in a REQ cycle:
  - drop cyc/stb at the next edge;
  - if read, dout <= ws_dout[32*idx +: 32];
  - if write, dout is unchanged;
  - next state DONE.
- Timeout:
  - counter == TIMEOUT-1 with no ack: drop cyc/stb, dout <= ERR_DATA on reads, err <= 1, next state DONE.
  - Simultaneous ack and timeout: ack wins, err unchanged.
- DONE:
  - dout is valid in this cycle;
  - the CPU completes the access;
  - next state IDLE unconditionally.
  - An en seen in DONE is the completing access, not a new request.
- Minimum latency: en at T0, REQ at T1 with ack, DONE at T2. nak is high in T0–T1, so there are 2 stall cycles.
- ack while in IDLE or DONE is ignored.
- The bridge never issues back-to-back cycles: cyc is low for at least the DONE and IDLE cycles.
- rst mid-REQ: cyc/stb low at the next edge, state IDLE, err cleared. A late ack after reset is ignored.
- err is cleared only by rst.

Decomposition:
- Shared package (bus_pkg):
  - state encoding IDLE/REQ/DONE (2 bits);
  - LINE_W and the word-index width (4);
  - constant ERR_DATA.
- One sub-module, line_lane_mux: combinational 32-from-LINE_W read select and dm-to-ws_dm placement. It is reused by the L2 side.
- The FSM and the timeout counter live in the top.

Test Plan:
1. Read, immediate ack: addr=0x0000_1048, ack in the first REQ cycle, ws_dout lane 2=0x1234_5678 → ws_addr=0x0000_1040, ws_we=0, nak high 2 cycles, dout=0x1234_5678 in DONE.
2. Write, ack after 5 cycles: addr=0x0000_207C, din=0xCAFE_F00D, dm=4'b0011 → ws_we=1, ws_dm has only bits [61:60]=2'b11 set, cyc high 5 cycles, nak released in DONE.
3. Timeout with TIMEOUT=8 and no ack, read → cyc drops after 8 REQ cycles, dout=0xDEAD_BEEF, err=1 and stays 1 through later good accesses.
4. ack in the same cycle the counter hits TIMEOUT-1 → normal data returned, err=0.
5. rst asserted during the 3rd REQ cycle, then a late ack → cyc=0 and state IDLE the next cycle, ack ignored, nak=0.
6. en held continuously across two accesses at 0x0 then 0x40 → exactly two Wishbone cycles, with cyc low between them for ≥2 cycles.
